// File: rtl/div_unit_if.sv
// Handshake/result bundle between the execute stage and the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic             cancel;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             div_stall;
  logic             ready;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_zero;

  modport master (
    output start, signed_div, cancel, opa, opb,
    input  div_stall, ready, hi_out, lo_out, div_zero
  );

  modport slave (
    input  start, signed_div, cancel, opa, opb,
    output div_stall, ready, hi_out, lo_out, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: quotient -> LO, remainder -> HI.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero completes in one cycle and flags div_zero.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic        clk,
  input logic        rst,
  div_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, nextState;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic             quoNeg, remNeg;
  logic [CNT_W-1:0] count;
`ifdef DIV_ZERO_FAST_EN
  logic             zeroFlag;
`endif

  logic             accept, lastIter, noBorrow, opbZero;
  logic [WIDTH-1:0] magA, magB, remNext, quoNext, loFix, hiFix;
  logic [WIDTH:0]   shRem, trial;

  always_comb begin
    accept   = (state == IDLE) && bus.start && !bus.cancel;
    opbZero  = (bus.opb == '0);
    magA     = (bus.signed_div && bus.opa[WIDTH-1]) ? -bus.opa : bus.opa;
    magB     = (bus.signed_div && bus.opb[WIDTH-1]) ? -bus.opb : bus.opb;
    // Shifted remainder kept one bit wider so 2*rem+1 never overflows the trial compare.
    shRem    = {rem, quo[WIDTH-1]};
    noBorrow = (shRem >= {1'b0, divisor});
    trial    = shRem - {1'b0, divisor};
    remNext  = noBorrow ? trial[WIDTH-1:0] : shRem[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], noBorrow};
    loFix    = quoNeg ? -quoNext : quoNext;
    hiFix    = remNeg ? -remNext : remNext;
    lastIter = (count == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_FAST_EN
          nextState = opbZero ? DONE : BUSY;
`else
          nextState = BUSY;
`endif
        end
      end
      BUSY: begin
        if (bus.cancel)    nextState = IDLE;
        else if (lastIter) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.div_stall = accept || (state == BUSY);
    bus.ready     = (state == DONE) && !bus.cancel;
`ifdef DIV_ZERO_FAST_EN
    bus.div_zero  = (state == DONE) && !bus.cancel && zeroFlag;
`else
    bus.div_zero  = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem        <= '0;
      quo        <= '0;
      divisor    <= '0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      count      <= '0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
`ifdef DIV_ZERO_FAST_EN
      zeroFlag   <= 1'b0;
`endif
    end else if (accept) begin
      rem     <= '0;
      quo     <= magA;
      divisor <= magB;
      quoNeg  <= bus.signed_div && (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
      remNeg  <= bus.signed_div && bus.opa[WIDTH-1];
      count   <= '0;
`ifdef DIV_ZERO_FAST_EN
      zeroFlag <= opbZero;
      if (opbZero) begin
        bus.hi_out <= bus.opa;
        bus.lo_out <= '0;
      end
`endif
    end else if (state == BUSY && !bus.cancel) begin
      rem   <= remNext;
      quo   <= quoNext;
      count <= count + 1'b1;
      if (lastIter) begin
        bus.hi_out <= hiFix;
        bus.lo_out <= loFix;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomised and directed checks of div_unit against a transaction-level reference model.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference result: hardware truncating division for nonzero divisors,
  // all-ones quotient / dividend remainder (sign-fixed for DIV) for zero.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                 output logic [W-1:0] lo, output logic [W-1:0] hi);
    longint sa, sb, q, r;
    logic [W-1:0] ma, qm;
    if (!sgn) begin
      if (b == 0) begin lo = '1; hi = a; end
      else begin lo = a / b; hi = a % b; end
    end else if (b == 0) begin
      ma = a[W-1] ? -a : a;
      qm = '1;
      lo = a[W-1] ? -qm : qm;
      hi = a[W-1] ? -ma : ma;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[W-1:0];
      hi = r[W-1:0];
    end
  endfunction

  int           busyLeft = 0;
  bit           doneNow  = 1'b0;
  bit           mZero    = 1'b0;
  logic [W-1:0] expHi = '0, expLo = '0, pendHi = '0, pendLo = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      busyLeft = 0; doneNow = 0; mZero = 0; expHi = '0; expLo = '0;
    end else if (doneNow) begin
      doneNow = 0; mZero = 0;
    end else if (busyLeft > 0) begin
      if (bus.cancel) busyLeft = 0;
      else begin
        busyLeft--;
        if (busyLeft == 0) begin
          doneNow = 1; expHi = pendHi; expLo = pendLo;
        end
      end
    end else if (bus.start && !bus.cancel) begin
`ifdef DIV_ZERO_FAST_EN
      if (bus.opb == 0) begin
        doneNow = 1; mZero = 1; expHi = bus.opa; expLo = '0;
      end else
`endif
      begin
        refDiv(bus.opa, bus.opb, bus.signed_div, pendLo, pendHi);
        busyLeft = W;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("stall", bus.div_stall,
            (busyLeft > 0) || (busyLeft == 0 && !doneNow && bus.start && !bus.cancel));
      check("ready", bus.ready, doneNow && !bus.cancel);
      check("div_zero", bus.div_zero, doneNow && mZero && !bus.cancel);
      check("hi", bus.hi_out, expHi);
      check("lo", bus.lo_out, expLo);
    end
  end

  task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [W-1:0] eLo, input logic [W-1:0] eHi, input int eLat,
                        input string name);
    int lat;
    bit got;
    @(posedge clk); #1;
    bus.start = 1; bus.opa = a; bus.opb = b; bus.signed_div = sgn;
    @(posedge clk); #1;
    bus.start = 0;
    lat = 0; got = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (bus.ready) begin got = 1; lat = k; end
    end
    check({name, ".lat"}, lat, eLat);
    check({name, ".lo"}, bus.lo_out, eLo);
    check({name, ".hi"}, bus.hi_out, eHi);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] lo, hi;
    bit seen;
    rst = 1;
    bus.start = 0; bus.signed_div = 0; bus.cancel = 0; bus.opa = '0; bus.opb = '0;

    refDiv(100, 7, 0, lo, hi);                        check("ref.100_7", {lo ^ 32'd14, hi ^ 32'd2}, '0);
    refDiv(32'hFFFF_FFF9, 2, 1, lo, hi);              check("ref.m7_2", {lo, hi}, 64'hFFFF_FFFD_FFFF_FFFF);
    refDiv(7, 32'hFFFF_FFFE, 1, lo, hi);              check("ref.7_m2", {lo, hi}, 64'hFFFF_FFFD_0000_0001);
    refDiv(32'h8000_0000, 32'hFFFF_FFFF, 1, lo, hi);  check("ref.ovf", {lo, hi}, 64'h8000_0000_0000_0000);
    refDiv(5, 0, 0, lo, hi);                          check("ref.5_0", {lo, hi}, 64'hFFFF_FFFF_0000_0005);

    #12;
    check("rst.ready", bus.ready, 0);
    check("rst.hi", bus.hi_out, 0);
    check("rst.lo", bus.lo_out, 0);
    check("rst.stall", bus.div_stall, 0);
    check("rst.div_zero", bus.div_zero, 0);
    @(posedge clk); #1 rst = 0;

    runDiv(100, 7, 0, 14, 2, 33, "divu100_7");
    runDiv(32'hFFFF_FFF9, 2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, "div_m7_2");
    runDiv(7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 1, 33, "div_7_m2");
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 33, "div_ovf");
`ifdef DIV_ZERO_FAST_EN
    runDiv(5, 0, 0, 0, 5, 1, "divu5_0");
    check("divu5_0.zero", bus.div_zero, 1);
`else
    runDiv(5, 0, 0, 32'hFFFF_FFFF, 5, 33, "divu5_0");
`endif

    // Cancel mid-flight keeps the previous result.
    runDiv(12, 5, 0, 2, 2, 33, "pre_cancel");
    @(posedge clk); #1 bus.start = 1; bus.opa = 50; bus.opb = 7; bus.signed_div = 0;
    @(posedge clk); #1 bus.start = 0;
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1;
    @(posedge clk); #1 bus.cancel = 0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.ready) seen = 1; end
    check("cancel.noready", seen, 0);
    check("cancel.hi", bus.hi_out, 2);
    check("cancel.lo", bus.lo_out, 2);
    runDiv(9, 3, 0, 3, 0, 33, "restart");

    // Cancel during DONE masks the strobe but results still land.
    @(posedge clk); #1 bus.start = 1; bus.opa = 20; bus.opb = 6;
    @(posedge clk); #1 bus.start = 0;
    repeat (32) @(posedge clk);
    #1 bus.cancel = 1;
    @(negedge clk);
    check("cdone.ready", bus.ready, 0);
    check("cdone.lo", bus.lo_out, 3);
    check("cdone.hi", bus.hi_out, 2);
    @(posedge clk); #1 bus.cancel = 0;

    // start together with cancel in IDLE is refused.
    @(posedge clk); #1 bus.start = 1; bus.cancel = 1;
    #1 check("startcancel.stall", bus.div_stall, 0);
    @(posedge clk); #1 bus.start = 0; bus.cancel = 0;
    @(negedge clk);
    check("startcancel.idle", bus.div_stall, 0);

    // Asynchronous reset mid-division, start held high throughout.
    @(posedge clk); #1 bus.start = 1; bus.opa = 1000; bus.opb = 3;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1 rst = 1;
    #1;
    check("arst.ready", bus.ready, 0);
    check("arst.hi", bus.hi_out, 0);
    check("arst.lo", bus.lo_out, 0);
    check("arst.div_zero", bus.div_zero, 0);
    repeat (3) @(posedge clk);
    #1 bus.start = 0; rst = 0;
    @(negedge clk);
    check("arst.stall", bus.div_stall, 0);
    check("arst.noready", bus.ready, 0);

    repeat (3000) begin
      @(posedge clk); #1;
      bus.start      = ($urandom % 6 == 0);
      bus.cancel     = ($urandom % 20 == 0);
      bus.signed_div = $urandom % 2;
      bus.opa        = pick();
      bus.opb        = pick();
    end
    @(posedge clk); #1 bus.start = 0; bus.cancel = 0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the execute stage of the 5-stage MIPS pipeline.
- Serves DIV/DIVU. Quotient goes to LO and remainder to HI; the HI/LO write is carried by the WriteHiLo pipeline signals.
- Raises a stall to the hazard unit while busy and presents a one-cycle result strobe on completion.
- flushE-driven cancel aborts an in-flight division.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a division; sampled in IDLE only.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- cancel  input  1  abort (driven from flushE); priority over all else.
- opa  input  WIDTH  dividend (rs); sampled with start.
- opb  input  WIDTH  divisor (rt); sampled with start.
- div_stall  output  1  combinational: (state==IDLE && start && !cancel) || state==BUSY.
- ready  output  1  result strobe, high only in DONE.
- hi_out  output  WIDTH  remainder, registered.
- lo_out  output  WIDTH  quotient, registered.
- div_zero  output  1  high with ready when opb was 0 (feature only; tied 0 otherwise).

Behaviour:
- Reset: state=IDLE; hi_out=0, lo_out=0, ready=0, div_zero=0; counter=0; internal regs cleared. Reset is asynchronous, takes effect mid-operation, and no result is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE -> BUSY at edge N when start=1 and cancel=0. At that edge, latch |opa| and |opb| (magnitude when signed_div, raw otherwise), the quotient sign (signA^signB), the remainder sign (signA), and set counter=0.
- BUSY performs one restoring iteration per edge, at edges N+1..N+32:
  - shift {rem,quo} left by 1;
  - trial = rem - divisor, computed at WIDTH+1 bits;
  - if no borrow: rem=trial and quo[0]=1; else quo[0]=0.
- At edge N+32 (counter==WIDTH-1), go to DONE and register the sign-fixed results into hi_out/lo_out. Negation is two's complement, truncated to WIDTH.
- DONE lasts exactly one cycle: ready=1. Next edge always -> IDLE.
- hi_out/lo_out hold their values until the next completion.
- Latency: start accepted at edge N -> ready high between edges N+32 and N+33.
- div_stall is low in DONE, so the pipeline advances while ready=1.
- start in BUSY or DONE is ignored. A new division is accepted only from IDLE, at the earliest edge N+34.
- cancel in BUSY -> IDLE at next edge; no ready; hi_out/lo_out unchanged.
- cancel in DONE: the DONE -> IDLE transition is unaffected, but ready is masked to 0.
- cancel together with start in IDLE: not accepted; div_stall=0.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): magnitudes are 2^31/1, giving quotient 0x80000000 and remainder 0. There is no trap.
- Divide by zero without the feature: the algorithm runs its full 32 iterations.
  - Unsigned: lo=0xFFFFFFFF, hi=opa.
  - Signed: the sign fixup is applied to those magnitudes.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: opb==0 at acceptance goes IDLE -> DONE directly, so ready is high in the cycle after edge N. Result is hi_out=opa, lo_out=0, div_zero=1 for that cycle. div_stall is high only in the accepting cycle.
- Undefined: no special path; div_zero is tied 0; divide-by-zero takes the full 32-iteration latency with the results given above.

Test Plan:
- DIVU 100/7 -> ready exactly 33 cycles after start edge; lo=14, hi=2; div_stall high for the 33 cycles from start through edge N+32.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/-2 -> lo=-3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; no hang.
- Cancel:
  - cancel at edge N+10 -> IDLE at N+11; ready never asserts; hi/lo keep the prior result (12/5 -> 2/2).
  - Restart at N+12: 9/3 -> lo=3, hi=0.
- Reset: rst pulse at edge N+20 -> state IDLE, all outputs 0 immediately (asynchronously). start held high during rst -> ignored.
- DIVU 5/0:
  - Without macro: lo=0xFFFFFFFF, hi=5 after 33 cycles.
  - With DIV_ZERO_FAST_EN: ready and div_zero high 1 cycle after start edge; hi=5, lo=0.
